// File: rtl/anode_controller.sv
// anode_controller: time-multiplexed 8-digit seven-segment scanner.
// Ports: clk, reset (sync, active-high), sel[2:0] (time/words/blink),
//   display_min_D1/D0, display_sec_D1/D0, display_words_3..0 (7-bit,
//   active-low segment patterns), AN[7:0] anodes, DP, display[6:0]
//   (all registered, active-low).
module anode_controller #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_TICKS = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sel,
    input  logic [6:0] display_min_D1,
    input  logic [6:0] display_min_D0,
    input  logic [6:0] display_sec_D1,
    input  logic [6:0] display_sec_D0,
    input  logic [6:0] display_words_3,
    input  logic [6:0] display_words_2,
    input  logic [6:0] display_words_1,
    input  logic [6:0] display_words_0,
    output logic [7:0] AN,
    output logic       DP,
    output logic [6:0] display
);

    // A divide-by-one still needs a 1-bit counter that sits at zero.
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_TICKS - 1);

    logic [PW-1:0] pre;
    logic [2:0]    idx;
    logic [BW-1:0] bcnt;
    logic          phase;

    logic          tick;
    logic          blink_wrap;
    logic          field_en;
    logic          digit_on;
    logic [6:0]    pattern;
    logic [7:0]    an_next;
    logic [6:0]    disp_next;
    logic          dp_next;

    always_comb begin
        tick       = (pre == PRE_MAX);
        blink_wrap = tick && (bcnt == BLK_MAX);

        // Upper four indices are the text field, lower four the clock.
        field_en = idx[2] ? sel[1] : sel[0];
        digit_on = field_en && (!sel[2] || phase);

        pattern = 7'h7F;
        unique case (idx)
            3'd7: pattern = display_words_3;
            3'd6: pattern = display_words_2;
            3'd5: pattern = display_words_1;
            3'd4: pattern = display_words_0;
            3'd3: pattern = display_min_D1;
            3'd2: pattern = display_min_D0;
            3'd1: pattern = display_sec_D1;
            3'd0: pattern = display_sec_D0;
        endcase

        an_next   = 8'hFF;
        disp_next = 7'h7F;
        dp_next   = 1'b1;
        if (digit_on) begin
            an_next   = ~(8'd1 << idx);
            disp_next = pattern;
            // Separator dot sits after the minutes-ones digit.
            dp_next   = (idx != 3'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre     <= '0;
            idx     <= 3'd0;
            bcnt    <= '0;
            phase   <= 1'b1;
            AN      <= 8'hFF;
            display <= 7'h7F;
            DP      <= 1'b1;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                idx <= idx + 3'd1;
                if (blink_wrap) begin
                    bcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end
            AN      <= an_next;
            display <= disp_next;
            DP      <= dp_next;
        end
    end

endmodule

// File: tb/tb_anode_controller.sv
// tb_anode_controller: directed self-checking bench for anode_controller
// with REFRESH_DIV=2, BLINK_TICKS=4.
module tb_anode_controller;

    localparam logic [6:0] M1 = 7'b1000000;
    localparam logic [6:0] M0 = 7'b1111001;
    localparam logic [6:0] S1 = 7'b0010010;
    localparam logic [6:0] S0 = 7'b0010010;
    localparam logic [6:0] W3 = 7'b1000111;
    localparam logic [6:0] W2 = 7'b0100011;
    localparam logic [6:0] W1 = 7'b1111111;
    localparam logic [6:0] W0 = 7'b1111111;
    localparam logic [6:0] BL = 7'h7F;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] sel = 3'b000;
    logic [6:0] min_d1 = M1;
    logic [6:0] min_d0 = M0;
    logic [6:0] sec_d1 = S1;
    logic [6:0] sec_d0 = S0;
    logic [6:0] w3 = W3;
    logic [6:0] w2 = W2;
    logic [6:0] w1 = W1;
    logic [6:0] w0 = W0;
    logic [7:0] an;
    logic       dp;
    logic [6:0] disp;

    int vectors = 0;
    int errors  = 0;

    anode_controller #(
        .REFRESH_DIV(2),
        .BLINK_TICKS(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sel            (sel),
        .display_min_D1 (min_d1),
        .display_min_D0 (min_d0),
        .display_sec_D1 (sec_d1),
        .display_sec_D0 (sec_d0),
        .display_words_3(w3),
        .display_words_2(w2),
        .display_words_1(w1),
        .display_words_0(w0),
        .AN             (an),
        .DP             (dp),
        .display        (disp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges, then release so the next edge is cycle k=1.
    task automatic do_reset(input logic [2:0] s);
        reset = 1'b1;
        step();
        step();
        sel   = s;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sel   = 3'b000;
        step();
        step();
        vectors++;
        if (an !== 8'hFF) begin
            errors++;
            $display("FAIL reset_an: got %h expected ff", an);
        end
        vectors++;
        if (disp !== BL) begin
            errors++;
            $display("FAIL reset_disp: got %h expected 7f", disp);
        end
        vectors++;
        if (dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_dp: got %b expected 1", dp);
        end
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            vectors++;
            if (an !== 8'hFF || disp !== BL || dp !== 1'b1) begin
                errors++;
                $display("FAIL blank_sel000 k=%0d: got an=%h disp=%h dp=%b expected ff/7f/1",
                         k, an, disp, dp);
            end
        end
    endtask

    task automatic test_time();
        logic [7:0] ea [16];
        logic [6:0] ed [16];
        logic       ep [16];
        ea = '{8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB, 8'hF7, 8'hF7,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        ed = '{S0, S0, S1, S1, M0, M0, M1, M1,
               BL, BL, BL, BL, BL, BL, BL, BL};
        ep = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset(3'b001);
        for (int k = 0; k < 16; k++) begin
            step();
            vectors++;
            if (an !== ea[k] || disp !== ed[k] || dp !== ep[k]) begin
                errors++;
                $display("FAIL time k=%0d: got an=%h disp=%b dp=%b expected an=%h disp=%b dp=%b",
                         k + 1, an, disp, dp, ea[k], ed[k], ep[k]);
            end
        end
    endtask

    task automatic test_words();
        logic [7:0] ea [16];
        logic [6:0] ed [16];
        ea = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
               8'hEF, 8'hEF, 8'hDF, 8'hDF, 8'hBF, 8'hBF, 8'h7F, 8'h7F};
        ed = '{BL, BL, BL, BL, BL, BL, BL, BL,
               W0, W0, W1, W1, W2, W2, W3, W3};
        do_reset(3'b010);
        for (int k = 0; k < 16; k++) begin
            step();
            vectors++;
            if (an !== ea[k] || disp !== ed[k] || dp !== 1'b1) begin
                errors++;
                $display("FAIL words k=%0d: got an=%h disp=%b dp=%b expected an=%h disp=%b dp=1",
                         k + 1, an, disp, dp, ea[k], ed[k]);
            end
        end
    endtask

    task automatic test_all_digits();
        logic [7:0] ea [16];
        ea = '{8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB, 8'hF7, 8'hF7,
               8'hEF, 8'hEF, 8'hDF, 8'hDF, 8'hBF, 8'hBF, 8'h7F, 8'h7F};
        do_reset(3'b011);
        for (int k = 0; k < 16; k++) begin
            step();
            vectors++;
            if (an !== ea[k] || $countones(~an) != 1) begin
                errors++;
                $display("FAIL all_digits k=%0d: got an=%h expected %h",
                         k + 1, an, ea[k]);
            end
        end
        step();
        vectors++;
        if (an !== 8'hFE || disp !== S0) begin
            errors++;
            $display("FAIL wrap_to_0: got an=%h disp=%b expected fe/%b",
                     an, disp, S0);
        end
    endtask

    task automatic test_blink();
        logic [7:0] vis [8];
        logic [7:0] exp_an;
        vis = '{8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB, 8'hF7, 8'hF7};
        do_reset(3'b111);
        for (int k = 1; k <= 32; k++) begin
            step();
            exp_an = (((k - 1) / 8) % 2 == 0) ? vis[(k - 1) % 8] : 8'hFF;
            vectors++;
            if (an !== exp_an) begin
                errors++;
                $display("FAIL blink k=%0d: got an=%h expected %h",
                         k, an, exp_an);
            end
        end
        for (int k = 33; k <= 42; k++) begin
            step();
        end
        vectors++;
        if (an !== 8'hFF) begin
            errors++;
            $display("FAIL blink_off k=42: got an=%h expected ff", an);
        end
        sel = 3'b011;
        step();
        vectors++;
        if (an !== 8'hDF || disp !== W1) begin
            errors++;
            $display("FAIL blink_restore: got an=%h disp=%b expected df/%b",
                     an, disp, W1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(3'b011);
        for (int k = 1; k <= 5; k++) begin
            step();
        end
        vectors++;
        if (an !== 8'hFB || dp !== 1'b0) begin
            errors++;
            $display("FAIL mid_pre: got an=%h dp=%b expected fb/0", an, dp);
        end
        sel = 3'b000;
        step();
        vectors++;
        if (an !== 8'hFF || dp !== 1'b1) begin
            errors++;
            $display("FAIL sel_off: got an=%h dp=%b expected ff/1", an, dp);
        end
        sel = 3'b011;
        min_d1 = 7'b0000000;
        step();
        vectors++;
        if (an !== 8'hF7 || disp !== 7'b0000000) begin
            errors++;
            $display("FAIL sel_on: got an=%h disp=%b expected f7/0000000",
                     an, disp);
        end
        min_d1 = M1;
        reset = 1'b1;
        step();
        vectors++;
        if (an !== 8'hFF || disp !== BL || dp !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got an=%h disp=%h dp=%b expected ff/7f/1",
                     an, disp, dp);
        end
        reset = 1'b0;
        step();
        vectors++;
        if (an !== 8'hFE) begin
            errors++;
            $display("FAIL restart_k1: got an=%h expected fe", an);
        end
        step();
        vectors++;
        if (an !== 8'hFE) begin
            errors++;
            $display("FAIL restart_k2: got an=%h expected fe", an);
        end
        step();
        vectors++;
        if (an !== 8'hFD) begin
            errors++;
            $display("FAIL restart_k3: got an=%h expected fd", an);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_time();
        test_words();
        test_all_digits();
        test_blink();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/anode_controller.md
ANODE_CONTROLLER -- requirements
Module: anode_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit-scan step (minimum 1).
REQ-002 Parameter BLINK_TICKS, default 500, scan steps per blink half-period (minimum 1).
REQ-003 clk  input  1  rising-edge clock, only clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sel  input  3  display mode: sel[0] time field enable, sel[1] words field enable, sel[2] blink enable.
REQ-006 display_min_D1, display_min_D0, display_sec_D1, display_sec_D0  input  7 each  active-low segment patterns for minutes tens/ones and seconds tens/ones.
REQ-007 display_words_3, display_words_2, display_words_1, display_words_0  input  7 each  active-low segment patterns for the text field, leftmost first.
REQ-008 AN  output  8  active-low digit anodes; at most one bit low at any time.
REQ-009 DP  output  1  active-low decimal point.
REQ-010 display  output  7  active-low segments for the currently enabled digit.

Function
REQ-011 A prescaler counts 0..REFRESH_DIV-1 and wraps; a scan tick occurs on the cycle it wraps.
REQ-012 A 3-bit scan index increments on each scan tick, wrapping 7->0.
REQ-013 Digit mapping by index: 7 words_3, 6 words_2, 5 words_1, 4 words_0, 3 min_D1, 2 min_D0, 1 sec_D1, 0 sec_D0.
REQ-014 Indices 7..4 belong to the words field; indices 3..0 belong to the time field.
REQ-015 A blink counter counts scan ticks 0..BLINK_TICKS-1; on wrap a blink phase bit toggles (1 = visible).
REQ-016 Current digit is enabled when its field enable bit in sel is 1 and (sel[2]=0 or blink phase=1).
REQ-017 Enabled digit: AN = all ones except bit[index] = 0; display = mapped input pattern.
REQ-018 Disabled digit: AN = 8'hFF, display = 7'h7F, DP = 1.
REQ-019 DP = 0 only when index = 2 and the digit is enabled (minutes/seconds separator); else DP = 1.
REQ-020 AN, display and DP are registered; they reflect index, sel, blink phase and segment inputs sampled at the previous rising edge (one-cycle latency).
REQ-021 sel and segment inputs take effect at the next rising edge regardless of scan position; no synchronization or debouncing.
REQ-022 sel = 3'b000 or 3'b100 blanks all digits; prescaler, index and blink counter keep running.
REQ-023 The blink counter runs regardless of sel[2]; sel[2] only gates visibility.
REQ-024 Prescaler, index and blink counter widths hold their maximum count with no overflow for any legal parameter value.

Reset
REQ-025 While reset is high at a rising edge: prescaler = 0, index = 0, blink counter = 0, blink phase = 1, AN = 8'hFF, display = 7'h7F, DP = 1.
REQ-026 Reset asserted mid-scan overrides all other activity on that edge; the first scan tick after release occurs REFRESH_DIV cycles after the first non-reset edge.

Verification (REFRESH_DIV=2, BLINK_TICKS=4)
REQ-027 Hold reset 2 cycles -> AN=8'hFF, display=7'h7F, DP=1; after release, with sel=3'b000, outputs stay blank for 40 cycles.
REQ-028 Inputs min_D1=7'b1000000, min_D0=7'b1111001, sec_D1=7'b0010010, sec_D0=7'b0010010, sel=3'b001 -> AN cycles FE,FD,FB,F7 with matching patterns, DP=0 only while AN=FB, then blank for indices 4..7.
REQ-029 Words 7'b1000111, 7'b0100011, 7'b1111111, 7'b1111111, sel=3'b010 -> AN EF..7F show words_0..words_3; indices 0..3 blank, DP always 1.
REQ-030 sel=3'b011 -> all eight AN values FE..7F appear in index order, each held 2 cycles, one anode low per cycle.
REQ-031 sel=3'b111 -> digits visible for 4 scan ticks (8 cycles), fully blank for next 8 cycles, repeating; sel=3'b011 restores continuous display next edge.
REQ-032 Change sel 3'b011->3'b000 mid-digit -> AN=8'hFF exactly one edge later; assert reset mid-scan -> index restarts at 0 (AN=FE first when enabled).
